axis_ch_arbiter: RTL and testbench

AXIS_CH_ARBITER -- requirements
Module: axis_ch_arbiter

---
 rtl/daq_pkg.sv | 15 +
 rtl/axi_if.sv | 16 +
 rtl/rr_select.sv | 29 ++
 rtl/axis_ch_arbiter.sv | 137 +++++++++++++
 tb/tb_axis_ch_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/daq_pkg.sv
// Shared types and helpers for the DAQ stream-merging blocks.
// Holds the arbiter FSM state encoding and the channel-index width derivation.
package daq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Width of a channel index; never below one bit so single-channel builds still elaborate.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4-Stream bundle used between the channel arbiter and the downstream FIFO.
interface axi_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 8
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);

endinterface

// File: rtl/rr_select.sv
// Round-robin selector: picks the first requester strictly after ptr, wrapping modulo N.
module rr_select
  import daq_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = ch_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_ch_arbiter.sv
// Merges N_CH AXI-Stream inputs into one registered output, granting whole bursts round-robin.
// Bursts end on the source tlast or after MAX_BURST beats, whichever comes first.
module axis_ch_arbiter
  import daq_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int USER_W    = 8,
  parameter  int N_CH      = 4,
  parameter  int MAX_BURST = 16,
  localparam int CH_W      = ch_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          s_tvalid,
  output logic [N_CH-1:0]          s_tready,
  input  logic [N_CH*DATA_W-1:0]   s_tdata,
  input  logic [N_CH-1:0]          s_tlast,
  input  logic [N_CH*USER_W-1:0]   s_tuser,
  axi_if.master                    m_axi_if,
  output logic [CH_W-1:0]          grant_id,
  output logic                     busy
);

  localparam int              BEAT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              mvalid_q, mvalid_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              mlast_q, mlast_d;
  logic [USER_W-1:0] muser_q, muser_d;

  logic [CH_W-1:0]   rr_grant;
  logic              rr_any;
  logic              out_free;
  logic              accept;
  logic              eff_last;
  logic [DATA_W-1:0] sel_data;
  logic [USER_W-1:0] sel_user;

  rr_select #(.N(N_CH)) u_rr_select (
    .req   (s_tvalid & ch_en),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .any   (rr_any)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !mvalid_q || m_axi_if.tready;
  assign sel_data = s_tdata[grant_q*DATA_W +: DATA_W];
  assign sel_user = s_tuser[grant_q*USER_W +: USER_W];
  assign accept   = (state_q == XFER) && out_free && s_tvalid[grant_q];
  assign eff_last = s_tlast[grant_q] || (beat_q == LAST_BEAT);

  always_comb begin
    s_tready = '0;
    if (state_q == XFER && out_free) begin
      s_tready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    muser_d  = muser_q;

    case (state_q)
      IDLE: begin
        if (rr_any) begin
          grant_d = rr_grant;
          ptr_d   = rr_grant;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (eff_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Low tuser bits are replaced by the source channel so the sink can demultiplex.
    if (accept) begin
      mvalid_d              = 1'b1;
      mdata_d               = sel_data;
      mlast_d               = eff_last;
      muser_d               = sel_user;
      muser_d[CH_W-1:0]     = grant_q;
    end else if (m_axi_if.tready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= CH_W'(N_CH - 1);
      beat_q   <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mlast_q  <= 1'b0;
      muser_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mlast_q  <= mlast_d;
      muser_q  <= muser_d;
    end
  end

  assign m_axi_if.tvalid = mvalid_q;
  assign m_axi_if.tdata  = mdata_q;
  assign m_axi_if.tlast  = mlast_q;
  assign m_axi_if.tuser  = muser_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q == XFER);

endmodule

// File: tb/tb_axis_ch_arbiter.sv
// Scoreboard bench for axis_ch_arbiter: per-channel packet drivers, a burst-level
// round-robin reference model, and an independent output monitor.
module tb_axis_ch_arbiter;

  localparam int DATA_W    = 32;
  localparam int USER_W    = 8;
  localparam int N_CH      = 4;
  localparam int MAX_BURST = 16;
  localparam int CH_W      = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  logic                   clk;
  logic                   rst;
  logic [N_CH-1:0]        ch_en;
  logic [N_CH-1:0]        s_tvalid;
  logic [N_CH-1:0]        s_tready;
  logic [N_CH*DATA_W-1:0] s_tdata;
  logic [N_CH-1:0]        s_tlast;
  logic [N_CH*USER_W-1:0] s_tuser;
  logic [CH_W-1:0]        grant_id;
  logic                   busy;
  logic                   mReady;

  axi_if #(.DATA_W(DATA_W), .USER_W(USER_W)) mAxi ();
  assign mAxi.tready = mReady;

  axis_ch_arbiter #(
    .DATA_W(DATA_W), .USER_W(USER_W), .N_CH(N_CH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tuser(s_tuser), .m_axi_if(mAxi),
    .grant_id(grant_id), .busy(busy)
  );

  beat_t           drvQ[N_CH][$];
  beat_t           mdlQ[N_CH][$];
  beat_t           expQ[$];
  int              acceptQ[$];
  logic [N_CH-1:0] fire;
  logic [N_CH-1:0] mdlEn;
  int              modelPtr;
  bit              randReady;
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic failNote(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Input beats keep the source tlast; expected output beats get burst-split tlast and channel tag.
  task automatic applyStimulus(input int ch, input int n, input logic [DATA_W-1:0] base);
    beat_t inB, outB;
    for (int k = 0; k < n; k++) begin
      inB.data = base + DATA_W'(k);
      inB.user = USER_W'($urandom);
      inB.last = (k == n - 1);
      outB = inB;
      outB.last = inB.last || ((k % MAX_BURST) == MAX_BURST - 1);
      outB.user[CH_W-1:0] = CH_W'(ch);
      drvQ[ch].push_back(inB);
      mdlQ[ch].push_back(outB);
    end
  endtask

  // Burst-level model: every channel with pending data is requesting, so the grant
  // sequence is fixed by rotating through enabled channels after the last one served.
  function automatic void runModel();
    int    pick;
    beat_t b;
    do begin
      pick = -1;
      for (int k = 1; k <= N_CH; k++) begin
        if (pick < 0 && mdlEn[(modelPtr + k) % N_CH] && mdlQ[(modelPtr + k) % N_CH].size() > 0)
          pick = (modelPtr + k) % N_CH;
      end
      if (pick >= 0) begin
        modelPtr = pick;
        do begin
          b = mdlQ[pick].pop_front();
          expQ.push_back(b);
        end while (!b.last && mdlQ[pick].size() > 0);
      end
    end while (pick >= 0);
  endfunction

  // Drivers: present the head of each channel queue, retire it after a handshake.
  initial begin
    beat_t tmp;
    fire = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) begin
        if (fire[c] && drvQ[c].size() > 0) tmp = drvQ[c].pop_front();
      end
      fire = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (drvQ[c].size() > 0) begin
          s_tvalid[c] = 1'b1;
          s_tdata[c*DATA_W +: DATA_W] = drvQ[c][0].data;
          s_tlast[c] = drvQ[c][0].last;
          s_tuser[c*USER_W +: USER_W] = drvQ[c][0].user;
        end else begin
          s_tvalid[c] = 1'b0;
          s_tlast[c]  = 1'b0;
        end
      end
      mReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      for (int c = 0; c < N_CH; c++) begin
        if (!rst && s_tvalid[c] && s_tready[c]) begin
          fire[c] = 1'b1;
          acceptQ.push_back(cyc);
        end
      end
    end
  end

  // Monitor: stability under backpressure, latency of each new beat, scoreboard on handshake.
  initial begin
    bit    newBeat = 1'b1;
    bit    held    = 1'b0;
    beat_t heldB, gotB, expB;
    int    acc;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        newBeat = 1'b1;
        held    = 1'b0;
      end else begin
        gotB = '{data: mAxi.tdata, last: mAxi.tlast, user: mAxi.tuser};
        if (mAxi.tvalid) begin
          if (held) checkOutput("hold_stable", 64'(gotB), 64'(heldB));
          if (newBeat) begin
            if (acceptQ.size() == 0) failNote("latency", "output beat with no accepted input");
            else begin
              acc = acceptQ.pop_front();
              checkOutput("latency", 64'(cyc), 64'(acc + 1));
            end
          end
          if (mReady) begin
            if (expQ.size() == 0) failNote("scoreboard", "output beat while none expected");
            else begin
              expB = expQ.pop_front();
              checkOutput("m_tdata", 64'(gotB.data), 64'(expB.data));
              checkOutput("m_tlast", 64'(gotB.last), 64'(expB.last));
              checkOutput("m_tuser", 64'(gotB.user), 64'(expB.user));
            end
          end
        end
        newBeat = !mAxi.tvalid || mReady;
        held    = mAxi.tvalid && !mReady;
        heldB   = gotB;
      end
    end
  end

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_tvalid"}, 64'(mAxi.tvalid), 64'd0);
    checkOutput({tag, "_tdata"}, 64'(mAxi.tdata), 64'd0);
    checkOutput({tag, "_tlast"}, 64'(mAxi.tlast), 64'd0);
    checkOutput({tag, "_tuser"}, 64'(mAxi.tuser), 64'd0);
    checkOutput({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkZeroOutputs(tag);
    for (int c = 0; c < N_CH; c++) begin
      drvQ[c].delete();
      mdlQ[c].delete();
    end
    expQ.delete();
    acceptQ.delete();
    fire = '0;
    modelPtr = N_CH - 1;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic runPhase(input string name, input int budget);
    int t = 0;
    runModel();
    while (expQ.size() > 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (expQ.size() > 0) failNote({name, "_timeout"}, $sformatf("%0d beats still expected", expQ.size()));
    repeat (3) @(negedge clk);
    $display("[TB] phase %s done at cycle %0d", name, cyc);
  endtask

  initial begin
    int queued2;
    rst = 1'b1;
    ch_en = '1;
    mdlEn = '1;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    s_tuser = '0;
    mReady = 1'b1;
    randReady = 1'b0;
    modelPtr = N_CH - 1;
    repeat (3) @(negedge clk);
    #3;
    checkZeroOutputs("reset");
    rst = 1'b0;

    applyStimulus(0, 3, 32'h10);
    runPhase("single_packet", 200);

    doReset("reset2");
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < N_CH; c++) applyStimulus(c, 1, {8'(c), 8'(p), 16'h0});
    runPhase("rr_order", 400);

    applyStimulus(2, 40, 32'h0220_0000);
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < N_CH; c++)
        if (c != 2) applyStimulus(c, 2, {8'(c), 8'(8'h30 + p), 16'h0});
    runPhase("max_burst", 800);

    randReady = 1'b1;
    for (int p = 0; p < 6; p++)
      for (int c = 0; c < N_CH; c++)
        applyStimulus(c, $urandom_range(1, 20), {8'(c), 8'(8'h40 + p), 16'h0});
    runPhase("backpressure", 4000);

    ch_en = 4'b1011;
    mdlEn = 4'b1011;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < N_CH; c++)
        applyStimulus(c, $urandom_range(1, 6), {8'(c), 8'(8'h50 + p), 16'h0});
    queued2 = drvQ[2].size();
    runPhase("ch_en_mask", 2000);
    checkOutput("ch2_never_granted", 64'(drvQ[2].size()), 64'(queued2));
    drvQ[2].delete();
    mdlQ[2].delete();

    randReady = 1'b0;
    applyStimulus(1, 12, 32'h0160_0000);
    runModel();
    repeat (4) @(negedge clk);
    #3;
    ch_en[1] = 1'b0;
    mdlEn[1] = 1'b0;
    runPhase("en_drop_mid_burst", 200);
    checkOutput("ch1_burst_completed", 64'(drvQ[1].size()), 64'd0);
    applyStimulus(1, 2, 32'h0170_0000);
    applyStimulus(0, 2, 32'h0070_0000);
    runPhase("ch1_excluded", 200);
    checkOutput("ch1_excluded_after_drop", 64'(drvQ[1].size()), 64'd2);
    drvQ[1].delete();
    mdlQ[1].delete();

    ch_en = '1;
    mdlEn = '1;
    applyStimulus(3, 10, 32'h0380_0000);
    runModel();
    repeat (4) @(negedge clk);
    doReset("mid_burst_reset");
    applyStimulus(1, 1, 32'h0190_0000);
    applyStimulus(3, 1, 32'h0390_0000);
    applyStimulus(0, 1, 32'h0090_0000);
    applyStimulus(2, 1, 32'h0290_0000);
    runPhase("after_reset", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
